// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the front pipeline registers of the 5-stage
// MIPS core.
//   DW       datapath width (instruction, PC, operands, ALU result)
//   RW       register-number width
//   ctrl_t   decoded control word, 15 bits, alu_op in the LSBs
//   CTRL_NOP all-zero control word (bubble)
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    // Field order is fixed: the decoder drives this word as a flat 15-bit bus.
    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic       is_mem_inst;
        logic       is_word;
        logic       halted;
        logic [5:0] alu_op;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline register with asynchronous active-low reset, synchronous
// clear and hold.
//   clk    rising-edge clock
//   rst_b  asynchronous active-low reset, clears q
//   hold   1 = keep q
//   clear  1 = load zero at the edge; wins over hold
//   d      next value
//   q      registered value
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_front_regs.sv
// -----------------------------------------------------------------------------
// pipe_front_regs
// IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage MIPS core.
// All three stages advance together and freeze together on stall (the data
// cache is busy), so the cache sees a stable address and store data.
//
// Optional feature: define PIPE_FLUSH_EN to add the flush input, which turns
// IF/ID and ID/EX into a bubble at the edge (over stall); EX/MEM ignores it.
//
// Ports:
//   clk, rst_b            clock, asynchronous active-low reset
//   stall                 1 = hold every register
//   flush                 (PIPE_FLUSH_EN only) bubble IF/ID and ID/EX
//   if_inst, if_pc_plus_4 fetch outputs      -> id_inst, id_pc_plus_4
//   id_ctrl, id_rs_data, id_rt_data, id_imm, id_pc_plus_4, id_inst fields
//                                            -> ex_ctrl, ex_pc_plus_4,
//                                               ex_rs_data, ex_rt_data, ex_imm
//   ex_dest               combinational destination register from ID/EX
//   ex_alu_result, ex_rt_data, ex_dest, ex_ctrl flags
//                                            -> mem_alu_result, mem_rt_data,
//                                               mem_dest, mem_* control bits
// -----------------------------------------------------------------------------
module pipe_front_regs #(
    parameter int DW = pipe_pkg::DW,
    parameter int RW = pipe_pkg::RW
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            stall,
`ifdef PIPE_FLUSH_EN
    input  logic            flush,
`endif
    input  logic [DW-1:0]   if_inst,
    input  logic [DW-1:0]   if_pc_plus_4,
    output logic [DW-1:0]   id_inst,
    output logic [DW-1:0]   id_pc_plus_4,
    input  pipe_pkg::ctrl_t id_ctrl,
    input  logic [DW-1:0]   id_rs_data,
    input  logic [DW-1:0]   id_rt_data,
    input  logic [DW-1:0]   id_imm,
    output pipe_pkg::ctrl_t ex_ctrl,
    output logic [DW-1:0]   ex_pc_plus_4,
    output logic [DW-1:0]   ex_rs_data,
    output logic [DW-1:0]   ex_rt_data,
    output logic [DW-1:0]   ex_imm,
    output logic [RW-1:0]   ex_dest,
    input  logic [DW-1:0]   ex_alu_result,
    output logic [DW-1:0]   mem_alu_result,
    output logic [DW-1:0]   mem_rt_data,
    output logic [RW-1:0]   mem_dest,
    output logic            mem_write_en,
    output logic            mem_to_reg,
    output logic            mem_reg_write,
    output logic            mem_is_mem_inst,
    output logic            mem_is_word,
    output logic            mem_halted
);

    import pipe_pkg::*;

    localparam int IFID_W  = 2 * DW;
    localparam int IDEX_W  = CTRL_W + 4 * DW + 2 * RW;
    localparam int EXMEM_W = 2 * DW + RW + 6;

    // MIPS instruction fields: rt at [20:16], rd at [15:11].
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;

    // Bubble request for the two front stages.
    logic clear_front;
`ifdef PIPE_FLUSH_EN
    assign clear_front = flush;
`else
    assign clear_front = 1'b0;
`endif

    // ---------------- IF/ID ----------------
    logic [IFID_W-1:0] ifid_d, ifid_q;

    assign ifid_d                  = {if_inst, if_pc_plus_4};
    assign {id_inst, id_pc_plus_4} = ifid_q;

    pipe_stage_reg #(.W(IFID_W)) u_if_id (
        .clk   (clk),
        .rst_b (rst_b),
        .hold  (stall),
        .clear (clear_front),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    // ---------------- ID/EX ----------------
    logic [IDEX_W-1:0] idex_d, idex_q;
    logic [RW-1:0]     ex_rt_field;
    logic [RW-1:0]     ex_rd_field;

    // Register-number fields come from the IF/ID copy of the instruction so
    // they stay aligned with the control word decoded from it.
    assign idex_d = {id_ctrl, id_pc_plus_4, id_rs_data, id_rt_data, id_imm,
                     id_inst[RT_LSB +: RW], id_inst[RD_LSB +: RW]};
    assign {ex_ctrl, ex_pc_plus_4, ex_rs_data, ex_rt_data, ex_imm,
            ex_rt_field, ex_rd_field} = idex_q;

    pipe_stage_reg #(.W(IDEX_W)) u_id_ex (
        .clk   (clk),
        .rst_b (rst_b),
        .hold  (stall),
        .clear (clear_front),
        .d     (idex_d),
        .q     (idex_q)
    );

    // R-type writes rd, I-type writes rt.
    assign ex_dest = ex_ctrl.reg_dst ? ex_rd_field : ex_rt_field;

    // ---------------- EX/MEM ----------------
    logic [EXMEM_W-1:0] exmem_d, exmem_q;

    assign exmem_d = {ex_alu_result, ex_rt_data, ex_dest,
                      ex_ctrl.mem_write, ex_ctrl.mem_to_reg, ex_ctrl.reg_write,
                      ex_ctrl.is_mem_inst, ex_ctrl.is_word, ex_ctrl.halted};
    assign {mem_alu_result, mem_rt_data, mem_dest,
            mem_write_en, mem_to_reg, mem_reg_write,
            mem_is_mem_inst, mem_is_word, mem_halted} = exmem_q;

    // Flush never reaches EX/MEM: an access already issued to the cache must
    // keep its address and data until the cache reports done.
    pipe_stage_reg #(.W(EXMEM_W)) u_ex_mem (
        .clk   (clk),
        .rst_b (rst_b),
        .hold  (stall),
        .clear (1'b0),
        .d     (exmem_d),
        .q     (exmem_q)
    );

endmodule

// File: tb/tb_pipe_front_regs.sv
// Testbench for pipe_front_regs: reference model with an expected-output
// queue, directed scenarios and a randomized run.
module tb_pipe_front_regs;
  import pipe_pkg::*;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          stall;
  logic          flush;
  logic [DW-1:0] if_inst, if_pc_plus_4, id_inst, id_pc_plus_4;
  ctrl_t         id_ctrl, ex_ctrl;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [DW-1:0] ex_pc_plus_4, ex_rs_data, ex_rt_data, ex_imm;
  logic [RW-1:0] ex_dest, mem_dest;
  logic [DW-1:0] ex_alu_result, mem_alu_result, mem_rt_data;
  logic          mem_write_en, mem_to_reg, mem_reg_write;
  logic          mem_is_mem_inst, mem_is_word, mem_halted;

  pipe_front_regs #(.DW(DW), .RW(RW)) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .stall           (stall),
`ifdef PIPE_FLUSH_EN
    .flush           (flush),
`endif
    .if_inst         (if_inst),
    .if_pc_plus_4    (if_pc_plus_4),
    .id_inst         (id_inst),
    .id_pc_plus_4    (id_pc_plus_4),
    .id_ctrl         (id_ctrl),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .ex_ctrl         (ex_ctrl),
    .ex_pc_plus_4    (ex_pc_plus_4),
    .ex_rs_data      (ex_rs_data),
    .ex_rt_data      (ex_rt_data),
    .ex_imm          (ex_imm),
    .ex_dest         (ex_dest),
    .ex_alu_result   (ex_alu_result),
    .mem_alu_result  (mem_alu_result),
    .mem_rt_data     (mem_rt_data),
    .mem_dest        (mem_dest),
    .mem_write_en    (mem_write_en),
    .mem_to_reg      (mem_to_reg),
    .mem_reg_write   (mem_reg_write),
    .mem_is_mem_inst (mem_is_mem_inst),
    .mem_is_word     (mem_is_word),
    .mem_halted      (mem_halted)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [DW-1:0] id_inst;
    logic [DW-1:0] id_pc;
    ctrl_t         ex_ctrl;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_rs;
    logic [DW-1:0] ex_rt;
    logic [DW-1:0] ex_imm;
    logic [RW-1:0] ex_dest;
    logic [DW-1:0] mem_alu;
    logic [DW-1:0] mem_rt;
    logic [RW-1:0] mem_dest;
    logic [5:0]    mem_flags; // write, to_reg, reg_write, is_mem, is_word, halted
  } out_t;

  localparam int OW = $bits(out_t);

  logic [OW-1:0] exp_q[$];
  out_t          m;          // expected register contents
  logic [RW-1:0] m_rt_f, m_rd_f;
  int            n_tests = 0;
  int            n_fail  = 0;
  string         phase   = "init";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  function automatic out_t sample();
    out_t s;
    s.id_inst   = id_inst;
    s.id_pc     = id_pc_plus_4;
    s.ex_ctrl   = ex_ctrl;
    s.ex_pc     = ex_pc_plus_4;
    s.ex_rs     = ex_rs_data;
    s.ex_rt     = ex_rt_data;
    s.ex_imm    = ex_imm;
    s.ex_dest   = ex_dest;
    s.mem_alu   = mem_alu_result;
    s.mem_rt    = mem_rt_data;
    s.mem_dest  = mem_dest;
    s.mem_flags = {mem_write_en, mem_to_reg, mem_reg_write,
                   mem_is_mem_inst, mem_is_word, mem_halted};
    return s;
  endfunction

  task automatic compare_out(input out_t e, input out_t a);
    check("id_inst",   64'(a.id_inst),   64'(e.id_inst));
    check("id_pc",     64'(a.id_pc),     64'(e.id_pc));
    check("ex_ctrl",   64'(a.ex_ctrl),   64'(e.ex_ctrl));
    check("ex_pc",     64'(a.ex_pc),     64'(e.ex_pc));
    check("ex_rs",     64'(a.ex_rs),     64'(e.ex_rs));
    check("ex_rt",     64'(a.ex_rt),     64'(e.ex_rt));
    check("ex_imm",    64'(a.ex_imm),    64'(e.ex_imm));
    check("ex_dest",   64'(a.ex_dest),   64'(e.ex_dest));
    check("mem_alu",   64'(a.mem_alu),   64'(e.mem_alu));
    check("mem_rt",    64'(a.mem_rt),    64'(e.mem_rt));
    check("mem_dest",  64'(a.mem_dest),  64'(e.mem_dest));
    check("mem_flags", 64'(a.mem_flags), 64'(e.mem_flags));
  endtask

  // Next expected state given the inputs currently driven.
  task automatic advance_model();
    out_t          n;
    logic [RW-1:0] nrt, nrd;
    n   = m;
    nrt = m_rt_f;
    nrd = m_rd_f;
    if (!stall) begin
      n.mem_alu   = ex_alu_result;
      n.mem_rt    = m.ex_rt;
      n.mem_dest  = m.ex_dest;
      n.mem_flags = {m.ex_ctrl.mem_write, m.ex_ctrl.mem_to_reg, m.ex_ctrl.reg_write,
                     m.ex_ctrl.is_mem_inst, m.ex_ctrl.is_word, m.ex_ctrl.halted};
      n.ex_ctrl   = id_ctrl;
      n.ex_pc     = m.id_pc;
      n.ex_rs     = id_rs_data;
      n.ex_rt     = id_rt_data;
      n.ex_imm    = id_imm;
      nrt         = m.id_inst[20:16];
      nrd         = m.id_inst[15:11];
      n.id_inst   = if_inst;
      n.id_pc     = if_pc_plus_4;
    end
    if (flush) begin
      n.id_inst = '0;
      n.id_pc   = '0;
      n.ex_ctrl = '0;
      n.ex_pc   = '0;
      n.ex_rs   = '0;
      n.ex_rt   = '0;
      n.ex_imm  = '0;
      nrt       = '0;
      nrd       = '0;
    end
    n.ex_dest = n.ex_ctrl.reg_dst ? nrd : nrt;
    m      = n;
    m_rt_f = nrt;
    m_rd_f = nrd;
  endtask

  // One clock: predict, push, wait for the edge, pop and compare.
  task automatic step();
    out_t e;
    advance_model();
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = out_t'(exp_q.pop_front());
    compare_out(e, sample());
  endtask

  // ---------------- driver ----------------
  task automatic drive_zero();
    if_inst       = '0;
    if_pc_plus_4  = '0;
    id_ctrl       = CTRL_NOP;
    id_rs_data    = '0;
    id_rt_data    = '0;
    id_imm        = '0;
    ex_alu_result = '0;
  endtask

  task automatic drive_random();
    if_inst       = $urandom;
    if_pc_plus_4  = $urandom;
    id_ctrl       = ctrl_t'($urandom_range(0, 32767));
    id_rs_data    = $urandom;
    id_rt_data    = $urandom;
    id_imm        = $urandom;
    ex_alu_result = $urandom;
  endtask

  task automatic model_reset();
    m      = '0;
    m_rt_f = '0;
    m_rd_f = '0;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    out_t          pre;
    ctrl_t         c;
    logic [DW-1:0] last_inst;

    rst_b = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive_zero();
    model_reset();

    // Reset state
    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    compare_out('0, sample());
    rst_b = 1'b1;

    // Pipeline flow: lw $2, 4($1)
    phase = "flow";
    if_inst      = 32'h8C220004;
    if_pc_plus_4 = 32'h00000010;
    step();
    check("flow_id_inst", 64'(id_inst), 64'h8C220004);
    check("flow_id_pc", 64'(id_pc_plus_4), 64'h10);
    if_inst       = '0;
    if_pc_plus_4  = '0;
    c             = CTRL_NOP;
    c.mem_to_reg  = 1'b1;
    c.alu_src     = 1'b1;
    c.reg_write   = 1'b1;
    c.is_mem_inst = 1'b1;
    c.is_word     = 1'b1;
    id_ctrl       = c;
    id_imm        = 32'h4;
    step();
    check("flow_ex_dest", 64'(ex_dest), 64'd2);
    check("flow_ex_pc", 64'(ex_pc_plus_4), 64'h10);
    id_ctrl       = CTRL_NOP;
    ex_alu_result = 32'h00000104;
    step();
    check("flow_mem_alu", 64'(mem_alu_result), 64'h104);
    check("flow_mem_dest", 64'(mem_dest), 64'd2);
    check("flow_mem_to_reg", 64'(mem_to_reg), 64'd1);

    // reg_dst mux: add $1, $2, $3
    phase = "reg_dst";
    drive_zero();
    if_inst = 32'h00430820;
    step();
    c         = CTRL_NOP;
    c.reg_dst = 1'b1;
    id_ctrl   = c;
    step();
    check("rd_sel", 64'(ex_dest), 64'd1);
    id_ctrl = CTRL_NOP;
    step();
    check("rt_sel", 64'(ex_dest), 64'd3);

    // Halt propagation
    phase = "halt";
    drive_zero();
    c        = CTRL_NOP;
    c.halted = 1'b1;
    id_ctrl  = c;
    step();
    check("halt_e1", 64'(mem_halted), 64'd0);
    id_ctrl = CTRL_NOP;
    step();
    check("halt_e2", 64'(mem_halted), 64'd1);
    step();
    check("halt_e3", 64'(mem_halted), 64'd0);

    // Stall: fill with random values, then freeze for 5 cycles
    phase = "stall";
    repeat (3) begin
      drive_random();
      step();
    end
    pre   = m;
    stall = 1'b1;
    repeat (5) begin
      drive_random();
      step();
      check("stall_id_inst", 64'(id_inst), 64'(pre.id_inst));
      check("stall_mem_alu", 64'(mem_alu_result), 64'(pre.mem_alu));
    end
    stall = 1'b0;
    drive_random();
    last_inst = if_inst;
    step();
    check("unstall_id_inst", 64'(id_inst), 64'(last_inst));
    check("unstall_ex_pc", 64'(ex_pc_plus_4), 64'(pre.id_pc));

`ifdef PIPE_FLUSH_EN
    // Flush over stall
    phase = "flush";
    drive_random();
    step();
    pre   = m;
    stall = 1'b1;
    flush = 1'b1;
    drive_random();
    step();
    check("flush_id_inst", 64'(id_inst), 64'd0);
    check("flush_ex_ctrl", 64'(ex_ctrl), 64'd0);
    check("flush_mem_alu", 64'(mem_alu_result), 64'(pre.mem_alu));
    stall = 1'b0;
    flush = 1'b0;
`endif

    // Randomized run with random stalls
    phase = "random";
    for (int i = 0; i < 60; i++) begin
      drive_random();
      stall = ($urandom_range(0, 3) == 0);
      step();
    end
    stall = 1'b0;

    // Asynchronous reset mid-cycle with non-zero inputs and state
    phase = "async_reset";
    drive_random();
    step();
    drive_random();
    step();
    #2;
    rst_b = 1'b0;
    #1;
    model_reset();
    compare_out('0, sample());
    @(posedge clk);
    #1;
    compare_out('0, sample());
    rst_b = 1'b1;
    drive_random();
    last_inst = if_inst;
    step();
    check("post_reset_id_inst", 64'(id_inst), 64'(last_inst));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
